// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one ultrasonic ranging unit among several sensors.
// Each round runs trigger, echo routing, result/timeout report and a quiet gap.
module sonar_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 600,
  parameter int TIMEOUT_CYCLES = 1_900_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter int SEL_W          = $clog2(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [N_SENSORS-1:0] sensor_mask_i,
  input  logic [N_SENSORS-1:0] sensor_echo_i,
  output logic [N_SENSORS-1:0] sensor_trig_o,
  output logic                 rng_trigger_o,
  output logic                 rng_echo_o,
  input  logic                 rng_trig_suc_i,
  input  logic                 rng_valid_i,
  input  logic [31:0]          rng_distance_i,
  output logic                 dist_valid_o,
  output logic [SEL_W-1:0]     dist_id_o,
  output logic [31:0]          dist_value_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_ECHO, GAP} state_e;

  localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [N_SENSORS-1:0] ONE_HOT0 = N_SENSORS'(1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [31:0]         timer_q, timer_d;
  logic                distValid_q, distValid_d;
  logic                timeout_q, timeout_d;
  logic [SEL_W-1:0]    distId_q, distId_d;
  logic [31:0]         distValue_q, distValue_d;

  // First set mask bit strictly after cur, wrapping; falls back to cur itself.
  function automatic logic [SEL_W-1:0] nextSet(input logic [SEL_W-1:0] cur,
                                               input logic [N_SENSORS-1:0] mask);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    res = cur;
    for (int k = N_SENSORS; k >= 1; k--) begin
      idx = SEL_W'((int'(cur) + k) % N_SENSORS);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      timer_q     <= '0;
      distValid_q <= 1'b0;
      timeout_q   <= 1'b0;
      distId_q    <= '0;
      distValue_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      distValid_q <= distValid_d;
      timeout_q   <= timeout_d;
      distId_q    <= distId_d;
      distValue_q <= distValue_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    timer_d     = timer_q + 32'd1;
    distValid_d = 1'b0;
    timeout_d   = 1'b0;
    distId_d    = distId_q;
    distValue_d = distValue_q;

    unique case (state_q)
      IDLE: begin
        if (enable_i && (|sensor_mask_i)) begin
          state_d = TRIG;
          if (!sensor_mask_i[sel_q]) sel_d = nextSet(sel_q, sensor_mask_i);
        end
      end
      TRIG: begin
        if (rng_trig_suc_i) begin
          state_d = WAIT_ECHO;
        end else if (timer_q == TRIG_LAST) begin
          distValid_d = 1'b1;
          timeout_d   = 1'b1;
          distValue_d = 32'hFFFF_FFFF;
          distId_d    = sel_q;
          state_d     = GAP;
        end
      end
      WAIT_ECHO: begin
        // A result arriving on the timeout cycle still counts as a measurement.
        if (rng_valid_i) begin
          distValid_d = 1'b1;
          distValue_d = rng_distance_i;
          distId_d    = sel_q;
          state_d     = GAP;
        end else if (timer_q == TIMEOUT_LAST) begin
          distValid_d = 1'b1;
          timeout_d   = 1'b1;
          distValue_d = 32'hFFFF_FFFF;
          distId_d    = sel_q;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (timer_q == GAP_LAST) begin
          sel_d   = nextSet(sel_q, sensor_mask_i);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q || state_q == IDLE) timer_d = '0;

    rng_trigger_o = (state_q == TRIG);
    sensor_trig_o = (state_q == TRIG) ? (ONE_HOT0 << sel_q) : '0;
    rng_echo_o    = (state_q == WAIT_ECHO) && sensor_echo_i[sel_q];
    busy_o        = (state_q != IDLE);
  end

  assign dist_valid_o = distValid_q;
  assign timeout_o    = timeout_q;
  assign dist_id_o    = distId_q;
  assign dist_value_o = distValue_q;

endmodule
